// File: rtl/ps2_mouse_tracker.sv
// Receive-only PS/2 mouse decoder: deserialises device-to-host frames, assembles
// 3-byte stream packets and integrates movement into screen-clamped coordinates.
module ps2_mouse_tracker #(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int X_INIT         = 320,
    parameter int Y_INIT         = 240,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic        lmb,
    output logic        mmb,
    output logic        rmb,
    output logic [15:0] mouse_x,
    output logic [15:0] mouse_y,
    output logic        packet_valid,
    output logic        frame_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic signed [17:0] X_MAX  = 18'(SCREEN_W - 1);
    localparam logic signed [17:0] Y_MAX  = 18'(SCREEN_H - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [2:0]       ps2c_sync_q;
    logic [1:0]       ps2d_sync_q;
    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_ok_q, par_ok_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       byte0_q, byte0_d;
    logic [7:0]       byte1_q, byte1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lmb_q, lmb_d, mmb_q, mmb_d, rmb_q, rmb_d;
    logic [15:0]      x_q, x_d, y_q, y_d;
    logic             pv_q, pv_d, ferr_q, ferr_d;

    logic             fe, din, timeout;
    logic signed [17:0] dx, dy, x_sum, y_sum;

    function automatic logic [15:0] clamp(input logic signed [17:0] v,
                                          input logic signed [17:0] hi);
        if (v < 18'sd0)
            return 16'd0;
        else if (v > hi)
            return hi[15:0];
        else
            return v[15:0];
    endfunction

    // Sync stage 1 is bit 0; bit 2 holds the previous synchronised clock level.
    assign fe  = ps2c_sync_q[2] & ~ps2c_sync_q[1];
    assign din = ps2d_sync_q[1];

    assign dx    = byte0_q[6] ? 18'sd0 : {{9{byte0_q[4]}}, byte0_q[4], byte1_q};
    assign dy    = byte0_q[7] ? 18'sd0 : {{9{byte0_q[5]}}, byte0_q[5], shift_q};
    assign x_sum = $signed({2'b00, x_q}) + dx;
    assign y_sum = $signed({2'b00, y_q}) - dy;

    assign timeout = !fe && (cnt_q == CNT_LAST) && (state_q != IDLE || idx_q != 2'd0);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        idx_d     = idx_q;
        byte0_d   = byte0_q;
        byte1_d   = byte1_q;
        cnt_d     = cnt_q;
        lmb_d     = lmb_q;
        mmb_d     = mmb_q;
        rmb_d     = rmb_q;
        x_d       = x_q;
        y_d       = y_q;
        pv_d      = 1'b0;
        ferr_d    = 1'b0;

        if (fe)
            cnt_d = '0;
        else if (cnt_q != CNT_SAT)
            cnt_d = cnt_q + 1'b1;

        if (timeout) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            ferr_d  = 1'b1;
        end else if (fe) begin
            case (state_q)
                IDLE: begin
                    if (!din) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7)
                        state_d = PARITY;
                end
                PARITY: begin
                    par_ok_d = (^shift_q) ^ din;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (din && par_ok_q) begin
                        case (idx_q)
                            2'd0: begin
                                // Bit 3 is always set in a header byte; anything else is a misaligned byte.
                                if (shift_q[3]) begin
                                    byte0_d = shift_q;
                                    idx_d   = 2'd1;
                                end
                            end
                            2'd1: begin
                                byte1_d = shift_q;
                                idx_d   = 2'd2;
                            end
                            default: begin
                                idx_d = 2'd0;
                                lmb_d = byte0_q[0];
                                rmb_d = byte0_q[1];
                                mmb_d = byte0_q[2];
                                x_d   = clamp(x_sum, X_MAX);
                                y_d   = clamp(y_sum, Y_MAX);
                                pv_d  = 1'b1;
                            end
                        endcase
                    end else begin
                        idx_d  = 2'd0;
                        ferr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2c_sync_q <= 3'b111;
            ps2d_sync_q <= 2'b11;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            par_ok_q    <= 1'b0;
            idx_q       <= 2'd0;
            byte0_q     <= 8'd0;
            byte1_q     <= 8'd0;
            cnt_q       <= '0;
            lmb_q       <= 1'b0;
            mmb_q       <= 1'b0;
            rmb_q       <= 1'b0;
            x_q         <= 16'(X_INIT);
            y_q         <= 16'(Y_INIT);
            pv_q        <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            ps2c_sync_q <= {ps2c_sync_q[1:0], ps2_clk};
            ps2d_sync_q <= {ps2d_sync_q[0], ps2_data};
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_ok_q    <= par_ok_d;
            idx_q       <= idx_d;
            byte0_q     <= byte0_d;
            byte1_q     <= byte1_d;
            cnt_q       <= cnt_d;
            lmb_q       <= lmb_d;
            mmb_q       <= mmb_d;
            rmb_q       <= rmb_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pv_q        <= pv_d;
            ferr_q      <= ferr_d;
        end
    end

    assign lmb          = lmb_q;
    assign mmb          = mmb_q;
    assign rmb          = rmb_q;
    assign mouse_x      = x_q;
    assign mouse_y      = y_q;
    assign packet_valid = pv_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Bench for ps2_mouse_tracker: directed test-plan packets followed by random
// bytes/errors/stalls, checked against a byte-queue reference model.
module tb_ps2_mouse_tracker;

    localparam int TO   = 200;
    localparam int HALF = 12;

    logic        clk = 1'b0;
    logic        reset, ps2_clk, ps2_data;
    logic        lmb, mmb, rmb, packet_valid, frame_err;
    logic [15:0] mouse_x, mouse_y;

    always #5 clk = ~clk;

    ps2_mouse_tracker #(
        .SCREEN_W(640), .SCREEN_H(480), .X_INIT(320), .Y_INIT(240), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .lmb(lmb), .mmb(mmb), .rmb(rmb), .mouse_x(mouse_x), .mouse_y(mouse_y),
        .packet_valid(packet_valid), .frame_err(frame_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts pulses and flags overlap or pulses wider than one cycle.
    int pv_cnt = 0, err_cnt = 0, bad_cnt = 0, pv_cyc = 0;
    logic pv_prev = 1'b0, fe_prev = 1'b0;
    always @(negedge clk) begin
        if (packet_valid === 1'b1) begin
            pv_cnt <= pv_cnt + 1;
            pv_cyc <= cyc;
        end
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
        if ((packet_valid && frame_err) || (packet_valid && pv_prev) || (frame_err && fe_prev))
            bad_cnt <= bad_cnt + 1;
        pv_prev <= packet_valid;
        fe_prev <= frame_err;
    end

    int checks = 0, errors = 0;
    int mx, my, exp_pv, exp_err, stop_cyc;
    bit ml, mm, mr;
    logic [7:0] q[$];

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        mx = 320; my = 240; ml = 0; mm = 0; mr = 0;
        q.delete();
    endtask

    // Reference: accepted bytes queue up; a header must have bit 3 set; three bytes make a move.
    task automatic model_byte(input logic [7:0] b);
        int dx, dy;
        if (q.size() == 0 && !b[3]) return;
        q.push_back(b);
        if (q.size() == 3) begin
            dx = q[0][6] ? 0 : (q[0][4] ? int'(q[1]) - 256 : int'(q[1]));
            dy = q[0][7] ? 0 : (q[0][5] ? int'(q[2]) - 256 : int'(q[2]));
            mx = mx + dx;
            my = my - dy;
            if (mx < 0) mx = 0;
            if (mx > 639) mx = 639;
            if (my < 0) my = 0;
            if (my > 479) my = 479;
            ml = q[0][0]; mr = q[0][1]; mm = q[0][2];
            exp_pv++;
            q.delete();
        end
    endtask

    task automatic verify();
        check("pv_count", pv_cnt, exp_pv);
        check("err_count", err_cnt, exp_err);
        check("pulse_shape", bad_cnt, 0);
        check("mouse_x", int'(mouse_x), mx);
        check("mouse_y", int'(mouse_y), my);
        check("lmb", int'(lmb), int'(ml));
        check("mmb", int'(mmb), int'(mm));
        check("rmb", int'(rmb), int'(mr));
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        int pv0;
        send_frame(b, 1'b0, 1'b0);
        pv0 = exp_pv;
        model_byte(b);
        verify();
        if (exp_pv != pv0)
            check("pv_latency", int'((pv_cyc - stop_cyc) inside {[2:5]}), 1);
    endtask

    task automatic send_bad(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_frame(b, bad_par, bad_stop);
        q.delete();
        exp_err++;
        verify();
    endtask

    task automatic stall();
        repeat (TO + 30) @(negedge clk);
        if (q.size() != 0) begin
            exp_err++;
            q.delete();
        end
        verify();
    endtask

    initial begin
        logic [7:0] b;
        int r;
        exp_pv = 0; exp_err = 0; stop_cyc = 0;
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        verify();

        // Reset in the middle of a packet and mid-frame.
        send_good(8'h09);
        send_good(8'h0A);
        @(negedge clk); ps2_data = 1'b0;
        repeat (HALF) @(negedge clk); ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk); ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (HALF) @(negedge clk); ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        reset = 1'b1; ps2_clk = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (10) @(negedge clk);
        verify();

        // Basic move.
        send_good(8'h09); send_good(8'h0A); send_good(8'h05);
        check("basic_x", int'(mouse_x), 330);
        check("basic_y", int'(mouse_y), 235);
        check("basic_lmb", int'(lmb), 1);

        // Negative delta and clamping.
        send_good(8'h18); send_good(8'h00); send_good(8'h00);
        check("neg_x", int'(mouse_x), 74);
        send_good(8'h18); send_good(8'h00); send_good(8'h00);
        check("clamp_x0", int'(mouse_x), 0);
        send_good(8'h28); send_good(8'h00); send_good(8'h00);
        check("clamp_ymax", int'(mouse_y), 479);

        // Parity and stop-bit errors, then recovery.
        send_good(8'h08); send_bad(8'h0A, 1'b1, 1'b0);
        send_good(8'h08); send_bad(8'h0A, 1'b0, 1'b1);
        send_good(8'h0C); send_good(8'h01); send_good(8'h00);
        check("recover_mmb", int'(mmb), 1);
        check("recover_x", int'(mouse_x), 1);

        // Resync and timeout.
        send_good(8'h00);
        send_good(8'h08); send_good(8'h05);
        stall();
        send_good(8'h08); send_good(8'h02); send_good(8'h00);
        check("resync_x", int'(mouse_x), 3);

        // Overflow suppresses x only.
        send_good(8'h4A); send_good(8'hFF); send_good(8'h03);
        check("ovf_x", int'(mouse_x), 3);
        check("ovf_rmb", int'(rmb), 1);

        // Random bytes, errors and stalls.
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 11);
            b = 8'($urandom);
            if (r == 0)      send_bad(b, 1'b1, 1'b0);
            else if (r == 1) send_bad(b, 1'b0, 1'b1);
            else if (r == 2) stall();
            else begin
                if (q.size() == 0 && $urandom_range(0, 3) != 0) b[3] = 1'b1;
                send_good(b);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_tracker.md
# ps2_mouse_tracker

- Receive-only PS/2 mouse decoder and position tracker.
- Deserialises the 11-bit PS/2 device-to-host frames and assembles standard 3-byte stream-mode packets.
- Integrates signed movement into absolute, screen-clamped coordinates.
- Drives the `lmb`/`mmb`/`rmb`/`mouse_x`/`mouse_y` inputs of the IO block that CPU code reads at 0xFF9/0xFF8/0xFF7.
- Never drives the PS/2 bus. Stream-mode enable (0xF4) is handled by a separate command block.

## Interface

Parameters:
- `SCREEN_W`, 640: x clamp range is 0..SCREEN_W-1.
- `SCREEN_H`, 480: y clamp range is 0..SCREEN_H-1.
- `X_INIT`, 320: `mouse_x` value after reset.
- `Y_INIT`, 240: `mouse_y` value after reset.
- `TIMEOUT_CYCLES`, 50000: `clk` cycles without a PS/2 falling edge before a partial frame/packet is abandoned (1 ms at 50 MHz).

Ports:
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: asynchronous, active-high.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `lmb`, `mmb`, `rmb` out 1 each: left, middle and right button state.
- `mouse_x` out 16: absolute x, unsigned.
- `mouse_y` out 16: absolute y, unsigned; 0 = top of screen.
- `packet_valid` out 1: one-cycle pulse when outputs update.
- `frame_err` out 1: one-cycle pulse on parity, stop-bit or timeout error.

## Operation

Input synchronisation and edge detection:
- `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser.
- A third flop on the synchronised clock forms a falling-edge strobe `fe`.
- All bit sampling uses the synchronised data on `fe`.

Frame FSM (IDLE, DATA, PARITY, STOP):
- IDLE: on `fe` with data=0 (start bit), go to DATA and clear the bit count. On `fe` with data=1, stay in IDLE.
- DATA: shift in 8 bits, LSB first. After the 8th, go to PARITY.
- PARITY: the 8 data bits XOR the parity bit must equal 1 (odd parity). Latch pass/fail and go to STOP.
- STOP: on `fe`, data must be 1 and parity must have passed; then the byte is accepted. Otherwise pulse `frame_err`. In both cases return to IDLE.
- Any frame error sets the packet byte index to 0.

Timeout:
- An idle counter clears on every `fe`.
- When it reaches TIMEOUT_CYCLES while the FSM is not in IDLE, or while the byte index is not 0:
  - FSM goes to IDLE and the byte index goes to 0;
  - `frame_err` pulses once;
  - the counter saturates until the next `fe`.

Packet assembly (byte index 0..2):
- Byte 0 is accepted only if bit3 = 1. Otherwise it is discarded and the index stays 0 (resync).
- Byte 0 bit fields: bit0 L, bit1 R, bit2 M, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
- Byte 1 is the dx low byte; byte 2 is the dy low byte.
- On acceptance of byte 2, the index returns to 0 and the update is applied.

Update arithmetic:
- dx = 9-bit two's complement {Xsign, byte1}; dy = {Ysign, byte2}.
- If an overflow bit is set, that axis delta is treated as 0.
- Both axes are computed 18-bit signed.
- x_new = x + dx, clamped to [0, SCREEN_W-1].
- y_new = y − dy (PS/2 +y is up), clamped to [0, SCREEN_H-1].
- Buttons are taken from byte 0 of the same packet. A packet with an overflow bit still updates the buttons.

## Timing

Reset values:
- `lmb`, `mmb`, `rmb`: 0.
- `mouse_x`: X_INIT. `mouse_y`: Y_INIT.
- `packet_valid`, `frame_err`: 0.
- FSM: IDLE; byte index: 0; idle counter: 0.
- Asserting reset mid-frame discards all partial state immediately.

Latency:
- Pin falling edge to `fe`: 3 `clk` cycles.
- Buttons, `mouse_x`, `mouse_y` and the `packet_valid` pulse are registered and change together, 1 cycle after the `fe` that samples the stop bit of byte 2.
- `frame_err` asserts 1 cycle after the failing stop-bit `fe`, or on the cycle the counter reaches TIMEOUT_CYCLES.

Constraints:
- `packet_valid` and `frame_err` are never high in the same cycle.
- Outputs hold their values between packets.
- PS/2 clock is 10–16.7 kHz; `clk` ≥ 1 MHz is required for correct edge detection.

## Test plan

- **Reset:** assert `reset` mid-frame → `mouse_x`=320, `mouse_y`=240, buttons 0, no pulses; next full packet decodes correctly.
- **Basic move:** send packet 0x09, 0x0A, 0x05 → `lmb`=1, `mouse_x`=330, `mouse_y`=235; `packet_valid` high exactly 1 cycle, 1 cycle after byte-2 stop bit.
- **Negative delta and clamp:** from x=330, send 0x18, 0x00, 0x00 twice → `mouse_x`=74, then 0; `mouse_y` unchanged. Send 0x28, 0x00, 0x00 from y=235 (dy=−256) → `mouse_y`=479.
- **Errors:** byte 1 sent with wrong parity → `frame_err` 1-cycle pulse, no output change, index reset; byte with stop bit 0 → same. Following valid packet 0x0C, 0x01, 0x00 → `mmb`=1, x+1.
- **Resync:** send 0x00 (bit3=0) → discarded. Send 0x08, 0x05, then stall more than TIMEOUT_CYCLES → `frame_err` pulse. Next 0x08, 0x02, 0x00 → x+2, not misaligned.
- **Overflow:** send 0x4A, 0xFF, 0x03 → `rmb`=1, `mouse_x` unchanged, `mouse_y` decreases by 3.
